// File: rtl/score_pkg.sv
// Shared constants, state encoding and helpers for the score BCD scheduler.
// Imported by the shared double-dabble engine and its arbiter.
package score_pkg;

    localparam int          BCD_DIGIT_W   = 4;
    localparam logic [3:0]  DABBLE_THRESH = 4'd5;
    localparam logic [3:0]  DABBLE_ADD    = 4'd3;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // A single requester still needs a one-bit id field.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD field >= 5, then shift left by one.
// The register layout is {BCD digits, binary operand}, with the MS digit at the top.
module bcd_dabble_step
    import score_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic [DIGITS*BCD_DIGIT_W+BIN_W-1:0] shift_i,
    output logic [DIGITS*BCD_DIGIT_W+BIN_W-1:0] shift_o
);

    localparam int SHIFT_W = DIGITS*BCD_DIGIT_W + BIN_W;

    logic [SHIFT_W-1:0] adjusted;

    // Each digit is corrected within its own 4-bit field; a carry never crosses fields.
    always_comb begin
        adjusted = shift_i;
        for (int d = 0; d < DIGITS; d++) begin
            if (adjusted[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] >= DABBLE_THRESH) begin
                adjusted[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    adjusted[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] + DABBLE_ADD;
            end
        end
        shift_o = {adjusted[SHIFT_W-2:0], 1'b0};
    end

endmodule

// File: rtl/score_bcd_scheduler.sv
// Round-robin arbiter that shares one iterative binary-to-BCD engine among N_REQ
// score requesters; each result is tagged with the id of the requester it belongs to.
module score_bcd_scheduler
    import score_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int BIN_W  = 8,
    parameter  int DIGITS = 3,
    localparam int ID_W   = idWidth(N_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*BIN_W-1:0]        bin_in,
    output logic [N_REQ-1:0]              ack,
    output logic                          busy,
    output logic                          result_valid,
    output logic [ID_W-1:0]               result_id,
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out
);

    localparam int BCD_W   = DIGITS*BCD_DIGIT_W;
    localparam int SHIFT_W = BCD_W + BIN_W;
    localparam int CNT_W   = $clog2(BIN_W + 1);

    state_e             state_q;
    logic [ID_W-1:0]    lastGrant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_d;
    logic [N_REQ-1:0]   ack_q;
    logic               busy_q;
    logic               resultValid_q;
    logic [ID_W-1:0]    resultId_q;
    logic [BCD_W-1:0]   bcd_q;

    logic               grantValid_d;
    logic [ID_W-1:0]    grant_d;
    logic [ID_W-1:0]    scanIdx;

    // Scan from farthest to nearest after the last grant so the nearest pending wins.
    always_comb begin
        grantValid_d = 1'b0;
        grant_d      = lastGrant_q;
        scanIdx      = lastGrant_q;
        for (int i = N_REQ; i >= 1; i--) begin
            scanIdx = ID_W'((int'(lastGrant_q) + i) % N_REQ);
            if (req[scanIdx]) begin
                grantValid_d = 1'b1;
                grant_d      = scanIdx;
            end
        end
    end

    bcd_dabble_step #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .shift_i (shift_q),
        .shift_o (shift_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lastGrant_q   <= ID_W'(N_REQ - 1);
            cnt_q         <= '0;
            shift_q       <= '0;
            ack_q         <= '0;
            busy_q        <= 1'b0;
            resultValid_q <= 1'b0;
            resultId_q    <= '0;
            bcd_q         <= '0;
        end else begin
            ack_q         <= '0;
            resultValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantValid_d) begin
                        shift_q     <= {{BCD_W{1'b0}}, bin_in[grant_d*BIN_W +: BIN_W]};
                        cnt_q       <= CNT_W'(BIN_W);
                        lastGrant_q <= grant_d;
                        ack_q       <= N_REQ'(1) << grant_d;
                        busy_q      <= 1'b1;
                        state_q     <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    // The step taken with one count left is the final one.
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q         <= shift_d[SHIFT_W-1 -: BCD_W];
                        resultId_q    <= lastGrant_q;
                        resultValid_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack          = ack_q;
    assign busy         = busy_q;
    assign result_valid = resultValid_q;
    assign result_id    = resultId_q;
    assign bcd_out      = bcd_q;

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Self-checking bench for score_bcd_scheduler: table of single conversions,
// hand-written round-robin and reset-abort sequences, and a random run against a model.
module tb_score_bcd_scheduler;

    localparam int N_REQ  = 2;
    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*BIN_W-1:0] bin_in;
    logic [N_REQ-1:0]       ack;
    logic                   busy;
    logic                   result_valid;
    logic [0:0]             result_id;
    logic [DIGITS*4-1:0]    bcd_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  reqMask;
        logic [7:0]  bin0;
        logic [7:0]  bin1;
        logic [11:0] expBcd;
        logic        expId;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    score_bcd_scheduler #(
        .N_REQ  (N_REQ),
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .bin_in       (bin_in),
        .ack          (ack),
        .busy         (busy),
        .result_valid (result_valid),
        .result_id    (result_id),
        .bcd_out      (bcd_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        reset  = 1'b1;
        req    = '0;
        bin_in = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [11:0] refBcd(input logic [7:0] v);
        int n;
        n = int'(v);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Runs one isolated conversion; the operand is scrambled after the grant edge.
    task automatic applyStimulus(input vec_t v);
        int busyCycles;
        int latency;
        bit got;
        req    = v.reqMask;
        bin_in = {v.bin1, v.bin0};
        tick();
        checkOutput("vec_ack", 32'(ack), 32'(v.reqMask));
        checkOutput("vec_busy_start", 32'(busy), 32'd1);
        req        = '0;
        bin_in     = ~bin_in;
        busyCycles = 1;
        latency    = 0;
        got        = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            latency++;
            if (result_valid) got = 1'b1;
            else if (busy) busyCycles++;
        end
        checkOutput("vec_result_seen", 32'(got), 32'd1);
        checkOutput("vec_bcd", 32'(bcd_out), 32'(v.expBcd));
        checkOutput("vec_id", 32'(result_id), 32'(v.expId));
        checkOutput("vec_busy_end", 32'(busy), 32'd0);
        checkOutput("vec_busy_cycles", 32'(busyCycles), 32'(BIN_W));
        checkOutput("vec_latency", 32'(latency), 32'(BIN_W));
        tick();
        checkOutput("vec_valid_pulse", 32'(result_valid), 32'd0);
        checkOutput("vec_bcd_held", 32'(bcd_out), 32'(v.expBcd));
    endtask

    initial begin
        logic [1:0]  ackSeq[4];
        logic [11:0] resBcd[4];
        logic        resId[4];
        int          resCycle[4];
        int          nAck;
        int          nRes;
        logic [7:0]  held[N_REQ];
        int          waitCnt[N_REQ];
        int          qId[$];
        logic [11:0] qVal[$];
        bit          sawValid;

        vecs[0] = '{2'b01, 8'd255, 8'd0,   12'h255, 1'b0};
        vecs[1] = '{2'b01, 8'd0,   8'd77,  12'h000, 1'b0};
        vecs[2] = '{2'b01, 8'd128, 8'd0,   12'h128, 1'b0};
        vecs[3] = '{2'b10, 8'd11,  8'd99,  12'h099, 1'b1};
        vecs[4] = '{2'b10, 8'd0,   8'd7,   12'h007, 1'b1};
        vecs[5] = '{2'b01, 8'd42,  8'd13,  12'h042, 1'b0};
        vecs[6] = '{2'b10, 8'd5,   8'd200, 12'h200, 1'b1};
        vecs[7] = '{2'b01, 8'd5,   8'd0,   12'h005, 1'b0};
        vecs[8] = '{2'b10, 8'd0,   8'd10,  12'h010, 1'b1};
        vecs[9] = '{2'b01, 8'd199, 8'd0,   12'h199, 1'b0};

        doReset();
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
        checkOutput("rst_id", 32'(result_id), 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Both requesters held high from reset: grants must alternate starting at 0.
        doReset();
        req    = 2'b11;
        bin_in = {8'd99, 8'd7};
        nAck   = 0;
        nRes   = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ack != 2'b00 && nAck < 4) begin
                ackSeq[nAck] = ack;
                nAck++;
            end
            if (result_valid && nRes < 4) begin
                resBcd[nRes]   = bcd_out;
                resId[nRes]    = result_id;
                resCycle[nRes] = c;
                nRes++;
            end
        end
        checkOutput("rr_ack_count", 32'(nAck), 32'd4);
        checkOutput("rr_res_count", 32'(nRes), 32'd4);
        for (int i = 0; i < 4 && i < nAck; i++)
            checkOutput("rr_ack_order", 32'(ackSeq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        for (int i = 0; i < 4 && i < nRes; i++) begin
            checkOutput("rr_res_bcd", 32'(resBcd[i]), (i % 2 == 0) ? 32'h007 : 32'h099);
            checkOutput("rr_res_id", 32'(resId[i]), 32'(i % 2));
        end
        for (int i = 1; i < 4 && i < nRes; i++)
            checkOutput("rr_res_spacing", 32'(resCycle[i] - resCycle[i-1]), 32'(BIN_W + 1));

        // Reset during the 4th conversion cycle aborts the conversion.
        doReset();
        req    = 2'b01;
        bin_in = {8'd0, 8'd200};
        tick();
        checkOutput("abort_ack", 32'(ack), 32'd1);
        req = 2'b00;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_bcd", 32'(bcd_out), 32'd0);
        sawValid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (result_valid) sawValid = 1'b1;
        end
        checkOutput("abort_no_valid", 32'(sawValid), 32'd0);
        req    = 2'b11;
        bin_in = {8'd1, 8'd2};
        tick();
        checkOutput("abort_regrant", 32'(ack), 32'd1);

        // Random traffic against a queue of expected results.
        doReset();
        for (int k = 0; k < N_REQ; k++) begin
            held[k]    = 8'd0;
            waitCnt[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (ack != '0) begin
                checkOutput("rnd_ack_onehot", 32'($onehot(ack)), 32'd1);
                for (int k = 0; k < N_REQ; k++) begin
                    if (ack[k]) begin
                        checkOutput("rnd_ack_requested", 32'(req[k]), 32'd1);
                        checkOutput("rnd_wait_bound", 32'(waitCnt[k] < N_REQ), 32'd1);
                        qId.push_back(k);
                        qVal.push_back(refBcd(held[k]));
                        waitCnt[k] = 0;
                        req[k]     = 1'b0;
                    end else if (req[k]) begin
                        waitCnt[k]++;
                    end
                end
            end
            if (result_valid) begin
                if (qId.size() == 0) begin
                    checkOutput("rnd_unexpected_valid", 32'(result_valid), 32'd0);
                end else begin
                    checkOutput("rnd_bcd", 32'(bcd_out), 32'(qVal.pop_front()));
                    checkOutput("rnd_id", 32'(result_id), 32'(qId.pop_front()));
                end
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (!req[k]) begin
                    held[k] = 8'($urandom_range(0, 255));
                    bin_in[k*BIN_W +: BIN_W] = held[k];
                    if ($urandom_range(0, 3) == 0) req[k] = 1'b1;
                end
            end
        end
        req = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (result_valid && qId.size() != 0) begin
                checkOutput("rnd_bcd", 32'(bcd_out), 32'(qVal.pop_front()));
                checkOutput("rnd_id", 32'(result_id), 32'(qId.pop_front()));
            end
        end
        checkOutput("rnd_drain", 32'(qId.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
